// File: rtl/mul_div_unit.sv
// mul_div_unit
//   Iterative multiply/divide unit for the EX stage. Computes the 64-bit
//   HI/LO result of mult, multu, div and divu, one iteration per cycle,
//   and reports busy/done so the hazard unit can stall dependent work.
//
// Ports
//   clk                     rising-edge clock
//   rst_n                   synchronous active-low reset
//   in_ID_EX_MulDiv_Start   single-cycle request
//   in_ID_EX_MulDiv_Op      00 multu, 01 mult, 10 divu, 11 div
//   in_ID_EX_Operand_A      rs (multiplicand / dividend)
//   in_ID_EX_Operand_B      rt (multiplier / divisor)
//   in_Pipeline_Flush       abort an in-flight operation
//   out_MulDiv_Busy         operation in progress
//   out_MulDiv_Done         one-cycle pulse, HI/LO valid
//   out_MulDiv_Hi           product high word / remainder
//   out_MulDiv_Lo           product low word / quotient
//   out_MulDiv_Div_By_Zero  last accepted divide had a zero divisor
//
// state | meaning
// IDLE  | waiting for a request
// RUN   | one shift-add / shift-subtract iteration per cycle
// FIX   | apply result signs, load HI/LO
// DONE  | result valid, Done pulse
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_ID_EX_MulDiv_Start,
  input  logic [1:0]       in_ID_EX_MulDiv_Op,
  input  logic [WIDTH-1:0] in_ID_EX_Operand_A,
  input  logic [WIDTH-1:0] in_ID_EX_Operand_B,
  input  logic             in_Pipeline_Flush,
  output logic             out_MulDiv_Busy,
  output logic             out_MulDiv_Done,
  output logic [WIDTH-1:0] out_MulDiv_Hi,
  output logic [WIDTH-1:0] out_MulDiv_Lo,
  output logic             out_MulDiv_Div_By_Zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t state, state_nxt;

  logic [CW-1:0]      cnt;
  logic               div_q;
  logic               sign_q;
  logic               sign_r;
  // mult: {partial product, remaining multiplier bits}
  // div:  low half shifts dividend bits out and quotient bits in
  logic [2*WIDTH-1:0] acc;
  // mult: multiplicand magnitude; div: divisor magnitude
  logic [WIDTH-1:0]   opb;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               dbz_q;

  logic               accept;
  logic               op_div;
  logic               sa;
  logic               sb;
  logic               div_zero;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh;
  logic               rem_ge;
  logic [WIDTH-1:0]   rem_sub;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign accept   = (state == IDLE) && in_ID_EX_MulDiv_Start && !in_Pipeline_Flush;
  assign op_div   = in_ID_EX_MulDiv_Op[1];
  assign sa       = in_ID_EX_MulDiv_Op[0] & in_ID_EX_Operand_A[WIDTH-1];
  assign sb       = in_ID_EX_MulDiv_Op[0] & in_ID_EX_Operand_B[WIDTH-1];
  assign div_zero = op_div && (in_ID_EX_Operand_B == '0);
  assign mag_a    = sa ? -in_ID_EX_Operand_A : in_ID_EX_Operand_A;
  assign mag_b    = sb ? -in_ID_EX_Operand_B : in_ID_EX_Operand_B;

  // Shift-add: add multiplicand into the upper half when the current
  // multiplier LSB is set, then shift the whole accumulator right with carry.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opb : '0)};
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Restoring divide: the extra top bit keeps the compare exact when the
  // shifted remainder overflows WIDTH bits. The difference always fits.
  assign rem_sh   = {rem, acc[WIDTH-1]};
  assign rem_ge   = rem_sh >= {1'b0, opb};
  assign rem_sub  = rem_sh[WIDTH-1:0] - opb;

  assign prod_fix = sign_q ? -acc : acc;
  assign quo_fix  = sign_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = sign_r ? -rem : rem;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = div_zero ? DONE : RUN;
      RUN: begin
        if (in_Pipeline_Flush) state_nxt = IDLE;
        else if (cnt == '0)    state_nxt = FIX;
      end
      FIX:  state_nxt = in_Pipeline_Flush ? IDLE : DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      div_q  <= 1'b0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      acc    <= '0;
      opb    <= '0;
      rem    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      dbz_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            div_q  <= op_div;
            sign_q <= sa ^ sb;
            sign_r <= sa;
            cnt    <= CW'(WIDTH - 1);
            rem    <= '0;
            dbz_q  <= div_zero;
            acc    <= {{WIDTH{1'b0}}, (op_div ? mag_a : mag_b)};
            opb    <= op_div ? mag_b : mag_a;
            if (div_zero) begin
              hi_q <= in_ID_EX_Operand_A;
              lo_q <= '1;
            end
          end
        end
        RUN: begin
          if (div_q) begin
            rem               <= rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
            acc[WIDTH-1:0]    <= {acc[WIDTH-2:0], rem_ge};
          end else begin
            acc <= mul_next;
          end
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        FIX: begin
          if (!in_Pipeline_Flush) begin
            if (div_q) begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end else begin
              hi_q <= prod_fix[2*WIDTH-1:WIDTH];
              lo_q <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign out_MulDiv_Busy        = (state == RUN) || (state == FIX);
  assign out_MulDiv_Done        = (state == DONE);
  assign out_MulDiv_Hi          = hi_q;
  assign out_MulDiv_Lo          = lo_q;
  assign out_MulDiv_Div_By_Zero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          flush = 1'b0;
  logic          busy, done, dbz;
  logic [W-1:0]  hi, lo;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .in_ID_EX_MulDiv_Start  (start),
    .in_ID_EX_MulDiv_Op     (op),
    .in_ID_EX_Operand_A     (a),
    .in_ID_EX_Operand_B     (b),
    .in_Pipeline_Flush      (flush),
    .out_MulDiv_Busy        (busy),
    .out_MulDiv_Done        (done),
    .out_MulDiv_Hi          (hi),
    .out_MulDiv_Lo          (lo),
    .out_MulDiv_Div_By_Zero (dbz)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the instruction definitions.
  function automatic logic [63:0] ref_calc(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy, q, r;
    logic [63:0] res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: res = {32'b0, x} * {32'b0, y};
      2'b01: res = sx * sy;
      2'b10: res = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
      default: begin
        if (y == 0) res = {x, 32'hFFFF_FFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          res = {r[31:0], q[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  // Transaction-level timing model: an accepted op produces its result
  // m_lat cycles after the accepting edge.
  bit          seen_rst = 0;
  bit          m_active = 0;
  int          m_t = 0;
  int          m_lat = 0;
  logic [63:0] m_pend = '0;
  logic [W-1:0] m_hi = '0, m_lo = '0;
  bit          m_dbz = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      seen_rst = 1;
      m_active = 0;
      m_hi = '0; m_lo = '0; m_dbz = 0;
    end else if (m_active) begin
      if (m_t == m_lat)  m_active = 0;
      else if (flush)    m_active = 0;
      else begin
        m_t++;
        if (m_t == m_lat) {m_hi, m_lo} = m_pend;
      end
    end else if (start && !flush) begin
      m_pend   = ref_calc(op, a, b);
      m_dbz    = op[1] && (b == 0);
      m_active = 1;
      m_t      = 1;
      m_lat    = m_dbz ? 1 : W + 2;
      if (m_lat == 1) {m_hi, m_lo} = m_pend;
    end
  end

  always @(negedge clk) begin
    if (seen_rst) begin
      check("busy", {31'b0, busy}, {31'b0, (m_active && m_t < m_lat)});
      check("done", {31'b0, done}, {31'b0, (m_active && m_t == m_lat)});
      check("hi",   hi, m_hi);
      check("lo",   lo, m_lo);
      check("dbz",  {31'b0, dbz}, {31'b0, m_dbz});
    end
  end

  task automatic start_req(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int c0, output int cyc);
    cyc = c0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] eh, input logic [W-1:0] el, input int elat);
    int cyc;
    start_req(o, x, y);
    wait_done(1, cyc);
    check("lit_latency", cyc, elat);
    check("lit_hi", hi, eh);
    check("lit_lo", lo, el);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom % 8)
      0: return '0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom % 16;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int cyc;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);

    run_op(2'b00, 32'd7, 32'd3, 32'h0, 32'h15, 34);
    run_op(2'b01, 32'hFFFF_FFFC, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFF4, 34);
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 34);
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34);
    run_op(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 34);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 34);
    run_op(2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1);
    check("lit_dbz_set", {31'b0, dbz}, 32'd1);
    run_op(2'b00, 32'd7, 32'd3, 32'h0, 32'h15, 34);
    check("lit_dbz_clr", {31'b0, dbz}, 32'd0);

    // flush mid-divide
    start_req(2'b11, 32'd9, 32'd2);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("lit_flush_busy", {31'b0, busy}, 32'd0);
    repeat (40) @(negedge clk);
    check("lit_flush_hi", hi, 32'h0);
    check("lit_flush_lo", lo, 32'h15);

    // reset mid-operation
    start_req(2'b00, 32'd11, 32'd13);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("lit_rst_busy", {31'b0, busy}, 32'd0);
    check("lit_rst_hi", hi, 32'd0);
    check("lit_rst_lo", lo, 32'd0);

    // start while busy, and start in the DONE cycle
    start_req(2'b00, 32'd2, 32'd2);
    repeat (3) @(negedge clk);
    op = 2'b01; a = 32'd5; b = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(5, cyc);
    check("lit_busy_latency", cyc, 34);
    check("lit_busy_lo", lo, 32'd4);
    op = 2'b01; a = 32'd5; b = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("lit_done_start_busy", {31'b0, busy}, 32'd0);
    check("lit_done_start_lo", lo, 32'd4);

    // randomized traffic checked by the model every cycle
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      start = ($urandom % 6) == 0;
      flush = ($urandom % 150) == 0;
      rst_n = ($urandom % 1500) != 0;
      op    = 2'($urandom % 4);
      a     = pick();
      b     = pick();
    end
    @(negedge clk);
    start = 1'b0; flush = 1'b0; rst_n = 1'b1;
    repeat (40) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
